// File: rtl/arf_sequencer_if.sv
// Command/response channel between the control unit and the ARF micro-sequencer.
// The control unit is the master; the sequencer is the slave.
interface arf_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       done;
  logic [7:0] rsp_data;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready, done, rsp_data);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready, done, rsp_data);
endinterface

// File: rtl/arf_sequencer.sv
// Moore micro-sequencer driving the address register file and memory strobes
// for fetch / jump / push / pop / call / return / clear operations.
module arf_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  arf_sequencer_if.slave   cmd,
  input  logic [7:0]       arf_outa,
  input  logic [7:0]       arf_outb,
  output logic [1:0]       arf_funsel,
  output logic [3:0]       arf_rsel,
  output logic [1:0]       arf_outasel,
  output logic [1:0]       arf_outbsel,
  output logic [7:0]       arf_i,
  output logic [7:0]       mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [7:0]       mem_rdata,
  output logic [7:0]       mem_wdata
);

  localparam logic [2:0] OP_NOP = 3'b000, OP_FETCH = 3'b001, OP_JUMP = 3'b010,
                         OP_PUSH = 3'b011, OP_POP = 3'b100, OP_CALL = 3'b101,
                         OP_RET = 3'b110, OP_CLR = 3'b111;

  localparam logic [1:0] FS_CLR = 2'b00, FS_LD = 2'b01, FS_INC = 2'b10, FS_DEC = 2'b11;
  localparam logic [3:0] R_PC = 4'b1000, R_SP = 4'b0010, R_PCP = 4'b0001, R_ALL = 4'b1111;
  localparam logic [1:0] SEL_SP = 2'b01, SEL_PC = 2'b11;

  typedef enum logic [4:0] {
    S_INIT, S_IDLE,
    S_F1, S_F2, S_F3,
    S_J1, S_CL1,
    S_PU1, S_PU2,
    S_PO1, S_PO2,
    S_CA1, S_CA2, S_CA3,
    S_RE1, S_RE2, S_RE3
  } state_t;

  state_t     state, state_nx;
  logic [7:0] cmd_data_q;
  logic [7:0] rsp_q;
  logic       done_q;
  logic       accept;
  logic       last;
  logic       capture;

  assign accept        = (state == S_IDLE) && cmd.cmd_valid;
  assign cmd.cmd_ready = (state == S_IDLE);
  assign cmd.done      = done_q;
  assign cmd.rsp_data  = rsp_q;
  assign mem_addr      = arf_outa;
  assign capture       = (state == S_F2) || (state == S_PO2) || (state == S_RE2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_INIT;
      done_q     <= 1'b0;
      rsp_q      <= 8'h00;
      cmd_data_q <= 8'h00;
    end else begin
      state  <= state_nx;
      done_q <= last || (accept && (cmd.cmd_op == OP_NOP));
      if (accept)  cmd_data_q <= cmd.cmd_data;
      if (capture) rsp_q      <= mem_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    last     = 1'b0;
    case (state)
      S_INIT: state_nx = S_IDLE;
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_FETCH: state_nx = S_F1;
            OP_JUMP:  state_nx = S_J1;
            OP_PUSH:  state_nx = S_PU1;
            OP_POP:   state_nx = S_PO1;
            OP_CALL:  state_nx = S_CA1;
            OP_RET:   state_nx = S_RE1;
            OP_CLR:   state_nx = S_CL1;
            default:  state_nx = S_IDLE;
          endcase
        end
      end
      S_F1:  state_nx = S_F2;
      S_F2:  state_nx = S_F3;
      S_PU1: state_nx = S_PU2;
      S_PO1: state_nx = S_PO2;
      S_CA1: state_nx = S_CA2;
      S_CA2: state_nx = S_CA3;
      S_RE1: state_nx = S_RE2;
      S_RE2: state_nx = S_RE3;
      S_F3, S_J1, S_CL1, S_PU2, S_PO2, S_CA3, S_RE3: begin
        state_nx = S_IDLE;
        last     = 1'b1;
      end
      default: state_nx = S_INIT;
    endcase
  end

  // OutSel is registered in the file, so each read state is preceded by a
  // state that already selects the same source.
  always_comb begin
    arf_funsel  = FS_CLR;
    arf_rsel    = 4'b0000;
    arf_outasel = 2'b00;
    arf_outbsel = 2'b00;
    arf_i       = cmd_data_q;
    mem_wdata   = cmd_data_q;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    case (state)
      S_INIT, S_CL1: begin
        arf_funsel = FS_CLR;
        arf_rsel   = R_ALL;
      end
      S_F1: arf_outasel = SEL_PC;
      S_F2: begin
        arf_outasel = SEL_PC;
        mem_rd      = 1'b1;
        arf_funsel  = FS_LD;
        arf_rsel    = R_PCP;
        arf_i       = arf_outa;
      end
      S_F3: begin
        arf_funsel = FS_INC;
        arf_rsel   = R_PC;
      end
      S_J1, S_CA3: begin
        arf_funsel = FS_LD;
        arf_rsel   = R_PC;
      end
      S_PU1: begin
        arf_funsel  = FS_DEC;
        arf_rsel    = R_SP;
        arf_outasel = SEL_SP;
      end
      S_PU2: begin
        arf_outasel = SEL_SP;
        mem_wr      = 1'b1;
      end
      S_PO1, S_RE1: arf_outasel = SEL_SP;
      S_PO2: begin
        arf_outasel = SEL_SP;
        mem_rd      = 1'b1;
        arf_funsel  = FS_INC;
        arf_rsel    = R_SP;
      end
      S_CA1: begin
        arf_funsel  = FS_DEC;
        arf_rsel    = R_SP;
        arf_outasel = SEL_SP;
        arf_outbsel = SEL_PC;
      end
      S_CA2: begin
        arf_outasel = SEL_SP;
        arf_outbsel = SEL_PC;
        mem_wr      = 1'b1;
        mem_wdata   = arf_outb;
      end
      S_RE2: begin
        arf_outasel = SEL_SP;
        mem_rd      = 1'b1;
        arf_funsel  = FS_LD;
        arf_rsel    = R_PC;
        arf_i       = mem_rdata;
      end
      S_RE3: begin
        arf_funsel = FS_INC;
        arf_rsel   = R_SP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: behavioural register file + memory around the DUT,
// a directed command table and hand-written reset/back-to-back sequences.
module tb_arf_sequencer;

  localparam logic [2:0] OP_NOP = 3'b000, OP_FETCH = 3'b001, OP_JUMP = 3'b010,
                         OP_PUSH = 3'b011, OP_POP = 3'b100, OP_CALL = 3'b101,
                         OP_RET = 3'b110, OP_CLR = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] arf_outa, arf_outb, arf_i, mem_addr, mem_rdata, mem_wdata;
  logic [1:0] arf_funsel, arf_outasel, arf_outbsel;
  logic [3:0] arf_rsel;
  logic       mem_rd, mem_wr;

  arf_sequencer_if cmd ();

  arf_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd),
    .arf_outa(arf_outa), .arf_outb(arf_outb),
    .arf_funsel(arf_funsel), .arf_rsel(arf_rsel),
    .arf_outasel(arf_outasel), .arf_outbsel(arf_outbsel), .arf_i(arf_i),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Register file model: registered OutSel, combinational read of the registers.
  logic [7:0] r_pc, r_ar, r_sp, r_pcp;
  logic [1:0] asel_q, bsel_q;

  function automatic logic [7:0] rd_reg(input logic [1:0] sel, input logic [7:0] ar,
                                        input logic [7:0] sp, input logic [7:0] pcp,
                                        input logic [7:0] pc);
    case (sel)
      2'b00:   return ar;
      2'b01:   return sp;
      2'b10:   return pcp;
      default: return pc;
    endcase
  endfunction

  function automatic logic [7:0] apply_fs(input logic [1:0] fs, input logic [7:0] cur,
                                          input logic [7:0] din);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return din;
      2'b10:   return cur + 8'h01;
      default: return cur - 8'h01;
    endcase
  endfunction

  assign arf_outa = rd_reg(asel_q, r_ar, r_sp, r_pcp, r_pc);
  assign arf_outb = rd_reg(bsel_q, r_ar, r_sp, r_pcp, r_pc);

  always @(posedge clk) begin
    asel_q <= arf_outasel;
    bsel_q <= arf_outbsel;
    if (arf_rsel[3]) r_pc  <= apply_fs(arf_funsel, r_pc, arf_i);
    if (arf_rsel[2]) r_ar  <= apply_fs(arf_funsel, r_ar, arf_i);
    if (arf_rsel[1]) r_sp  <= apply_fs(arf_funsel, r_sp, arf_i);
    if (arf_rsel[0]) r_pcp <= apply_fs(arf_funsel, r_pcp, arf_i);
  end

  // Memory model with a preload port used only during reset.
  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_a, ld_v;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en)       mem[ld_a]     <= ld_v;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  int n_wr = 0, n_done = 0;
  always @(negedge clk) begin
    if (mem_wr)   n_wr   <= n_wr + 1;
    if (cmd.done) n_done <= n_done + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, output int busy);
    int guard = 0;
    while (!cmd.cmd_ready && guard < 50) begin tick(); guard++; end
    chk("ready_before_cmd", cmd.cmd_ready, 1);
    cmd.cmd_valid = 1'b1; cmd.cmd_op = op; cmd.cmd_data = d;
    tick();
    cmd.cmd_valid = 1'b0; cmd.cmd_op = OP_CLR; cmd.cmd_data = 8'hEE;
    busy = 0;
    while (!cmd.done && busy < 20) begin
      chk("busy_ready_low", cmd.cmd_ready, 0);
      tick();
      busy++;
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    int         busy;
    logic [7:0] rsp, pc, sp, pcp, mff;
  } vec_t;

  initial begin
    vec_t vt [12];
    int   busy, base_wr, base_done, guard;
    logic [7:0] last_push;

    // State after the hand-written FETCH + PUSH 0x3C: PC 01, SP FF, PCPast 00, rsp A5.
    vt[0]  = '{OP_POP,   8'h00, 2, 8'h3C, 8'h01, 8'h00, 8'h00, 8'h3C};
    vt[1]  = '{OP_NOP,   8'h00, 0, 8'h3C, 8'h01, 8'h00, 8'h00, 8'h3C};
    vt[2]  = '{OP_JUMP,  8'h05, 1, 8'h3C, 8'h05, 8'h00, 8'h00, 8'h3C};
    vt[3]  = '{OP_CALL,  8'h40, 3, 8'h3C, 8'h40, 8'hFF, 8'h00, 8'h05};
    vt[4]  = '{OP_RET,   8'h00, 3, 8'h05, 8'h05, 8'h00, 8'h00, 8'h05};
    vt[5]  = '{OP_FETCH, 8'h00, 3, 8'h5A, 8'h06, 8'h00, 8'h05, 8'h05};
    vt[6]  = '{OP_CLR,   8'h00, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h05};
    vt[7]  = '{OP_PUSH,  8'h11, 2, 8'h5A, 8'h00, 8'hFF, 8'h00, 8'h11};
    vt[8]  = '{OP_PUSH,  8'h22, 2, 8'h5A, 8'h00, 8'hFE, 8'h00, 8'h11};
    vt[9]  = '{OP_POP,   8'h00, 2, 8'h22, 8'h00, 8'hFF, 8'h00, 8'h11};
    vt[10] = '{OP_POP,   8'h00, 2, 8'h11, 8'h00, 8'h00, 8'h00, 8'h11};
    vt[11] = '{OP_FETCH, 8'h00, 3, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h11};

    // Reset for two cycles while preloading mem[00]=A5 and mem[05]=5A.
    rst_n = 1'b0;
    cmd.cmd_valid = 1'b0; cmd.cmd_op = OP_NOP; cmd.cmd_data = 8'h00;
    ld_en = 1'b1; ld_a = 8'h00; ld_v = 8'hA5;
    tick();
    ld_a = 8'h05; ld_v = 8'h5A;
    tick();
    ld_en = 1'b0;
    chk("init_rsel", arf_rsel, 4'hF);
    chk("init_funsel", arf_funsel, 2'b00);
    chk("init_ready", cmd.cmd_ready, 0);
    chk("init_done", cmd.done, 0);
    chk("init_rsp", cmd.rsp_data, 8'h00);
    chk("init_strobes", {mem_rd, mem_wr}, 2'b00);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", cmd.cmd_ready, 1);
    chk("idle_rsel", arf_rsel, 4'h0);
    chk("idle_done", cmd.done, 0);
    chk("rst_pc", r_pc, 8'h00);
    chk("rst_sp", r_sp, 8'h00);

    // FETCH, cycle by cycle.
    cmd.cmd_valid = 1'b1; cmd.cmd_op = OP_FETCH; cmd.cmd_data = 8'h00;
    tick();
    cmd.cmd_valid = 1'b0;
    chk("f1_ready", cmd.cmd_ready, 0);
    chk("f1_outasel", arf_outasel, 2'b11);
    tick();
    chk("f2_rd", mem_rd, 1);
    chk("f2_addr", mem_addr, 8'h00);
    chk("f2_ctl", {arf_funsel, arf_rsel}, {2'b01, 4'b0001});
    tick();
    chk("f3_ctl", {arf_funsel, arf_rsel}, {2'b10, 4'b1000});
    chk("f3_done", cmd.done, 0);
    tick();
    chk("fetch_done", cmd.done, 1);
    chk("fetch_ready", cmd.cmd_ready, 1);
    chk("fetch_rsp", cmd.rsp_data, 8'hA5);
    chk("fetch_pc", r_pc, 8'h01);
    chk("fetch_pcp", r_pcp, 8'h00);

    // PUSH 0x3C: SP wraps to FF.
    cmd.cmd_valid = 1'b1; cmd.cmd_op = OP_PUSH; cmd.cmd_data = 8'h3C;
    tick();
    cmd.cmd_valid = 1'b0; cmd.cmd_data = 8'h00;
    chk("pu1_ctl", {arf_funsel, arf_rsel, arf_outasel}, {2'b11, 4'b0010, 2'b01});
    tick();
    chk("pu2_wr", mem_wr, 1);
    chk("pu2_addr", mem_addr, 8'hFF);
    chk("pu2_wdata", mem_wdata, 8'h3C);
    chk("pu2_sp", r_sp, 8'hFF);
    tick();
    chk("push_done", cmd.done, 1);
    chk("push_mem", mem[8'hFF], 8'h3C);
    chk("push_rsp_held", cmd.rsp_data, 8'hA5);

    // Directed command table.
    for (int i = 0; i < 12; i++) begin
      run_cmd(vt[i].op, vt[i].data, busy);
      chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("v%0d_done", i), cmd.done, 1);
      chk($sformatf("v%0d_ready", i), cmd.cmd_ready, 1);
      chk($sformatf("v%0d_rsp", i), cmd.rsp_data, vt[i].rsp);
      chk($sformatf("v%0d_pc", i), r_pc, vt[i].pc);
      chk($sformatf("v%0d_sp", i), r_sp, vt[i].sp);
      chk($sformatf("v%0d_pcp", i), r_pcp, vt[i].pcp);
      chk($sformatf("v%0d_memff", i), mem[8'hFF], vt[i].mff);
    end

    // Reset sampled at the CA2 edge aborts the CALL.
    cmd.cmd_valid = 1'b1; cmd.cmd_op = OP_CALL; cmd.cmd_data = 8'h80;
    tick();
    cmd.cmd_valid = 1'b0;
    tick();
    chk("ca2_wr", mem_wr, 1);
    chk("ca2_wdata", mem_wdata, 8'h01);
    rst_n = 1'b0;
    tick();
    base_wr = n_wr;
    chk("abort_rsel", arf_rsel, 4'hF);
    chk("abort_strobes", {mem_rd, mem_wr}, 2'b00);
    chk("abort_ready", cmd.cmd_ready, 0);
    chk("abort_done", cmd.done, 0);
    chk("abort_rsp", cmd.rsp_data, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("abort_pc", r_pc, 8'h00);
    chk("abort_sp", r_sp, 8'h00);
    chk("abort_idle_done", cmd.done, 0);
    chk("abort_idle_ready", cmd.cmd_ready, 1);
    tick();
    chk("abort_no_done", cmd.done, 0);
    chk("abort_no_write", n_wr, base_wr);

    // Held cmd_valid: alternating PUSH/POP, junk op while busy must be ignored.
    base_done = n_done;
    last_push = 8'h00;
    for (int k = 0; k < 10; k++) begin
      guard = 0;
      while (!cmd.cmd_ready && guard < 50) begin tick(); guard++; end
      chk($sformatf("b2b%0d_ready", k), cmd.cmd_ready, 1);
      cmd.cmd_valid = 1'b1;
      if (k % 2 == 0) begin
        cmd.cmd_op = OP_PUSH; cmd.cmd_data = 8'h50 + 8'(k); last_push = 8'h50 + 8'(k);
      end else begin
        cmd.cmd_op = OP_POP; cmd.cmd_data = 8'hEE;
      end
      tick();
      cmd.cmd_op = OP_CLR; cmd.cmd_data = 8'h99;
      busy = 0;
      while (!cmd.cmd_ready && busy < 20) begin
        chk($sformatf("b2b%0d_busy_done", k), cmd.done, 0);
        tick();
        busy++;
      end
      chk($sformatf("b2b%0d_busy", k), busy, 2);
      chk($sformatf("b2b%0d_done", k), cmd.done, 1);
      if (k % 2 == 1) chk($sformatf("b2b%0d_rsp", k), cmd.rsp_data, last_push);
    end
    cmd.cmd_valid = 1'b0;
    tick();
    chk("b2b_done_count", n_done - base_done, 10);
    chk("b2b_sp", r_sp, 8'h00);
    chk("b2b_idle_done", cmd.done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
